// File: rtl/clken_slot_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Package     : clken_pkg
// Description : Shared constants and helpers for the clken_slot_arbiter slice.
//               Requester index map, default window/requester counts and the
//               slot-counter width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package clken_pkg;

  // Requester index map for the shared slots
  localparam int REQ_VIDEO   = 0;
  localparam int REQ_LOADER  = 1;
  localparam int REQ_REFRESH = 2;

  // Default configuration: 7 sys_clock cycles per CPU enable, 3 requesters
  localparam int DIV_DEFAULT  = 7;
  localparam int NREQ_DEFAULT = 3;

  // Width of a counter/index able to hold 0..v-1, never narrower than 1 bit
  function automatic int clog2w(input int v);
    int r;
    r = $clog2(v);
    return (r < 1) ? 1 : r;
  endfunction

endpackage : clken_pkg
`default_nettype wire

// File: rtl/clken_slot_arbiter_if.sv
`default_nettype none
// ============================================================================
// Interface   : clken_slot_arbiter_if
// Description : Bus bundle between the slot arbiter and its clients.
//   cpu_pause  : client -> arbiter, withhold CPU slots (whole windows only)
//   req        : client -> arbiter, per-requester level request
//   cpu_clken  : arbiter -> clients, one-cycle CPU/device enable
//   gnt        : arbiter -> clients, one-hot one-cycle slot grant
//   slot       : arbiter -> clients, current slot index
//   cpu_paused : arbiter -> clients, pause currently in effect
//   Modports: master = arbiter side, slave = client side.
// Revision    : 1.0 - initial release
// ============================================================================
interface clken_slot_arbiter_if
  import clken_pkg::*;
#(
  parameter int DIV  = DIV_DEFAULT,
  parameter int NREQ = NREQ_DEFAULT
) ();

  localparam int CW = clog2w(DIV);

  logic            cpu_pause;
  logic [NREQ-1:0] req;
  logic            cpu_clken;
  logic [NREQ-1:0] gnt;
  logic [CW-1:0]   slot;
  logic            cpu_paused;

  modport master (
    input  cpu_pause,
    input  req,
    output cpu_clken,
    output gnt,
    output slot,
    output cpu_paused
  );

  modport slave (
    output cpu_pause,
    output req,
    input  cpu_clken,
    input  gnt,
    input  slot,
    input  cpu_paused
  );

endinterface : clken_slot_arbiter_if
`default_nettype wire

// File: rtl/clken_slot_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin selector. Picks the first set bit of
//               elig, searching upward from rr_ptr and wrapping modulo NREQ.
//   elig   : in  NREQ  eligible requesters
//   rr_ptr : in  PW    index where the search starts (always < NREQ)
//   onehot : out NREQ  one-hot of the chosen index (0 when none)
//   idx    : out PW    chosen index (0 when none)
//   any    : out 1     some requester was eligible
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
  import clken_pkg::*;
#(
  parameter int NREQ = NREQ_DEFAULT
) (
  input  logic [NREQ-1:0]          elig,
  input  logic [clog2w(NREQ)-1:0]  rr_ptr,
  output logic [NREQ-1:0]          onehot,
  output logic [clog2w(NREQ)-1:0]  idx,
  output logic                     any
);

  localparam int PW = clog2w(NREQ);

  int w_best_d;
  int w_best_i;
  int w_d;

  // The winner is the eligible index at the smallest forward distance from
  // rr_ptr; distance NREQ means "nobody found".
  always_comb begin
    w_best_d = NREQ;
    w_best_i = 0;
    w_d      = 0;
    for (int i = 0; i < NREQ; i++) begin
      if (elig[i]) begin
        w_d = (i + NREQ - int'(rr_ptr)) % NREQ;
        if (w_d < w_best_d) begin
          w_best_d = w_d;
          w_best_i = i;
        end
      end
    end
  end

  always_comb begin
    any    = (w_best_d < NREQ);
    idx    = any ? PW'(w_best_i) : '0;
    onehot = any ? (NREQ'(1) << w_best_i) : '0;
  end

endmodule : rr_pick
`default_nettype wire

// File: rtl/clken_slot_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : clken_slot_arbiter
// Description : Divides sys_clock into windows of DIV slots. Slot 0 issues the
//               one-cycle cpu_clken; the remaining slots (and slot 0 while the
//               CPU is paused) are handed out round-robin to NREQ requesters.
//   sys_clock : in  master clock
//   reset     : in  synchronous active-high reset
//   bus       : clken_slot_arbiter_if.master (cpu_pause, req in;
//               cpu_clken, gnt, slot, cpu_paused out)
// Revision    : 1.0 - initial release
// ============================================================================
module clken_slot_arbiter
  import clken_pkg::*;
#(
  parameter int DIV  = DIV_DEFAULT,
  parameter int NREQ = NREQ_DEFAULT
) (
  input  logic                 sys_clock,
  input  logic                 reset,
  clken_slot_arbiter_if.master bus
);

  localparam int CW = clog2w(DIV);
  localparam int PW = clog2w(NREQ);

  localparam logic [CW-1:0] c_last_slot = CW'(DIV - 1);
  localparam logic [PW-1:0] c_last_req  = PW'(NREQ - 1);

  logic [CW-1:0]   r_slot;
  logic            r_cpu_clken;
  logic [NREQ-1:0] r_gnt;
  logic            r_paused;
  logic [PW-1:0]   r_rr_ptr;

  logic            w_shared;
  logic [NREQ-1:0] w_elig;
  logic [NREQ-1:0] w_onehot;
  logic [PW-1:0]   w_idx;
  logic            w_any;

  // A paused CPU gives up its slot 0 to the requesters.
  assign w_shared = (r_slot != '0) || r_paused;

  // The current grant holder is masked so it cannot be regranted while it is
  // still dropping req; earliest regrant is therefore two cycles later.
  assign w_elig = bus.req & ~r_gnt;

  rr_pick #(
    .NREQ (NREQ)
  ) u_rr_pick (
    .elig   (w_elig),
    .rr_ptr (r_rr_ptr),
    .onehot (w_onehot),
    .idx    (w_idx),
    .any    (w_any)
  );

  always_ff @(posedge sys_clock) begin
    if (reset) begin
      r_slot      <= '0;
      r_cpu_clken <= 1'b0;
      r_gnt       <= '0;
      r_paused    <= 1'b0;
      r_rr_ptr    <= '0;
    end else begin
      r_slot      <= (r_slot == c_last_slot) ? '0 : r_slot + CW'(1);
      r_cpu_clken <= (r_slot == '0) && !r_paused;

      // Pause is only sampled on the last slot so it covers whole windows.
      if (r_slot == c_last_slot) begin
        r_paused <= bus.cpu_pause;
      end

      if (w_shared && w_any) begin
        r_gnt    <= w_onehot;
        r_rr_ptr <= (w_idx == c_last_req) ? '0 : w_idx + PW'(1);
      end else begin
        r_gnt    <= '0;
      end
    end
  end

  assign bus.cpu_clken  = r_cpu_clken;
  assign bus.gnt        = r_gnt;
  assign bus.slot       = r_slot;
  assign bus.cpu_paused = r_paused;

endmodule : clken_slot_arbiter
`default_nettype wire
